// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: initiator side of the 4-bit ALU operation interface.
// Accepts one command at a time, drives registered operands into the ALU,
// waits the ALU pipeline latency, captures the 8-bit result and returns it
// on a response channel.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid (and its payload) until that edge.
// Consumers may raise or drop ready at any time. rsp_valid and every rsp_*
// field are held stable until the transfer edge.
//
// Optional feature macro: ALU_SELFCHECK_EN adds a golden model that flags
// results disagreeing with the ALU contract (rsp_mismatch, err_count).
// Without it, rsp_mismatch and err_count are tied to zero.
module alu_cmd_issuer #(
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    output logic             alu_clr,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [7:0]       alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic [2:0]       rsp_op,
    output logic             rsp_mismatch,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [2:0]       LAT_C = 3'(ALU_LATENCY);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_e           state_q, state_d;
    logic             clr_q;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [2:0]       rop_q, rop_d;
    logic             rv_q, rv_d;
    logic [7:0]       res_q, res_d;
    logic [CNT_W-1:0] txn_q, txn_d;

    logic accept;
    logic capture;
    logic retire;

    // Ready only in IDLE once the ALU has seen its post-reset clear cycle.
    assign cmd_ready = (state_q == ST_IDLE) && !clr_q;
    assign accept    = cmd_valid && cmd_ready;
    assign capture   = (state_q == ST_WAIT) && (cnt_q == 3'd0);
    assign retire    = (state_q == ST_RESP) && rsp_ready;

    assign alu_clr    = clr_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp_valid  = rv_q;
    assign rsp_result = res_q;
    assign rsp_op     = rop_q;
    assign txn_count  = txn_q;

    // ALU clear is held through reset and released on the first clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clr_q <= 1'b1;
        else        clr_q <= 1'b0;
    end

    // Next-state and datapath updates for the IDLE -> WAIT -> RESP sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rop_d   = rop_q;
        rv_d    = rv_q;
        res_d   = res_q;
        txn_d   = txn_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    op_d    = cmd_op;
                    rop_d   = cmd_op;
                    cnt_d   = LAT_C;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (capture) begin
                    res_d   = alu_result;
                    rv_d    = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (retire) begin
                    rv_d    = 1'b0;
                    txn_d   = txn_q + ONE_C;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            op_q    <= 3'd0;
            rop_q   <= 3'd0;
            rv_q    <= 1'b0;
            res_q   <= 8'd0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rop_q   <= rop_d;
            rv_q    <= rv_d;
            res_q   <= res_d;
            txn_q   <= txn_d;
        end
    end

`ifdef ALU_SELFCHECK_EN
    // Reference ALU: operands zero-extended to 8 bits.
    function automatic logic [7:0] golden(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
        logic [7:0] ax;
        logic [7:0] bx;
        logic [7:0] r;
        ax = {4'h0, a};
        bx = {4'h0, b};
        case (op)
            3'd0:    r = ax + bx;
            3'd1:    r = ax - bx;
            3'd2:    r = ax & bx;
            3'd3:    r = ax | bx;
            3'd4:    r = ax ^ bx;
            3'd5:    r = ax >> b;
            3'd6:    r = ax << b;
            default: r = (a > b) ? 8'd1 : 8'd0;
        endcase
        return r;
    endfunction

    logic [7:0]       exp_q, exp_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] err_q, err_d;

    // Store expected result at accept, compare at capture, count at retire.
    always_comb begin
        exp_d = exp_q;
        mis_d = mis_q;
        err_d = err_q;
        if (accept)  exp_d = golden(cmd_a, cmd_b, cmd_op);
        if (capture) mis_d = (alu_result != exp_q);
        if (retire && mis_q && (err_q != {CNT_W{1'b1}})) err_d = err_q + ONE_C;
    end

    // Self-check registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= 8'd0;
            mis_q <= 1'b0;
            err_q <= '0;
        end else begin
            exp_q <= exp_d;
            mis_q <= mis_d;
            err_q <= err_d;
        end
    end

    assign rsp_mismatch = mis_q;
    assign err_count    = err_q;
`else
    assign rsp_mismatch = 1'b0;
    assign err_count    = '0;
`endif

endmodule
